// File: rtl/median_window_reader_if.sv
// median_window_reader_if: start/status, image-memory read port and window-pixel stream
// of the median window reader.
interface median_window_reader_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       mem_read_enable;
    logic [7:0] mem_read_x;
    logic [7:0] mem_read_y;
    logic       mem_data_in;
    logic       data_valid;
    logic       data_out;
    logic [7:0] x_address_out;
    logic [7:0] y_address_out;

    modport master (
        input  start, mem_data_in,
        output busy, done, mem_read_enable, mem_read_x, mem_read_y,
               data_valid, data_out, x_address_out, y_address_out
    );

    modport slave (
        output start, mem_data_in,
        input  busy, done, mem_read_enable, mem_read_x, mem_read_y,
               data_valid, data_out, x_address_out, y_address_out
    );
endinterface

// File: rtl/median_window_reader.sv
// median_window_reader: scans every interior window of an image in raster order and streams
// its pixels as one tagged burst per window, tag = window bottom-right coordinate.
module median_window_reader #(
    parameter int WINDOW_SIZE = 3,
    parameter int IMG_WIDTH   = 256,
    parameter int IMG_HEIGHT  = 256,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    median_window_reader_if.master io_bus
);
    localparam int OFF = WINDOW_SIZE / 2;
    localparam int CW  = $clog2(WINDOW_SIZE);
    localparam logic [CW-1:0] C_LAST  = CW'(WINDOW_SIZE - 1);
    localparam logic [7:0]    C_OFF   = 8'(OFF);
    localparam logic [7:0]    CX_LAST = 8'(IMG_WIDTH - 1 - OFF);
    localparam logic [7:0]    CY_LAST = 8'(IMG_HEIGHT - 1 - OFF);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_GAP, S_DRAIN, S_DONE} state_t;

    state_t           r_state, w_state_n;
    logic [7:0]       r_cx, r_cy, w_cx_n, w_cy_n;
    logic [CW-1:0]    r_r, r_c, w_r_n, w_c_n;
    logic [7:0]       r_rd_x, r_rd_y;
    logic [MEM_LATENCY-1:0] r_pipe_v;
    logic [7:0]       r_pipe_x [MEM_LATENCY];
    logic [7:0]       r_pipe_y [MEM_LATENCY];
    logic             r_dv, r_dout;
    logic [7:0]       r_xo, r_yo;
    logic             w_last_px, w_last_win;

    assign w_last_px  = (r_r == C_LAST) && (r_c == C_LAST);
    assign w_last_win = (r_cx == CX_LAST) && (r_cy == CY_LAST);

    // Offsets stay parked on the last pixel through GAP so the read address holds.
    always_comb begin
        w_state_n = r_state;
        w_cx_n    = r_cx;
        w_cy_n    = r_cy;
        w_r_n     = r_r;
        w_c_n     = r_c;
        case (r_state)
            S_IDLE: if (io_bus.start) begin
                w_state_n = S_FETCH;
                w_cx_n    = C_OFF;
                w_cy_n    = C_OFF;
                w_r_n     = '0;
                w_c_n     = '0;
            end
            S_FETCH: if (w_last_px) w_state_n = w_last_win ? S_DRAIN : S_GAP;
            else begin
                w_c_n = (r_c == C_LAST) ? '0 : r_c + 1'b1;
                w_r_n = (r_c == C_LAST) ? r_r + 1'b1 : r_r;
            end
            S_GAP: begin
                w_state_n = S_FETCH;
                w_r_n     = '0;
                w_c_n     = '0;
                w_cx_n    = (r_cx == CX_LAST) ? C_OFF : r_cx + 8'd1;
                w_cy_n    = (r_cx == CX_LAST) ? r_cy + 8'd1 : r_cy;
            end
            S_DRAIN: if (r_pipe_v == '0) w_state_n = S_DONE;
            S_DONE:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= S_IDLE;
            r_cx     <= '0;
            r_cy     <= '0;
            r_r      <= '0;
            r_c      <= '0;
            r_rd_x   <= '0;
            r_rd_y   <= '0;
            r_pipe_v <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                r_pipe_x[i] <= '0;
                r_pipe_y[i] <= '0;
            end
            r_dv     <= 1'b0;
            r_dout   <= 1'b0;
            r_xo     <= '0;
            r_yo     <= '0;
        end else begin
            r_state <= w_state_n;
            r_cx    <= w_cx_n;
            r_cy    <= w_cy_n;
            r_r     <= w_r_n;
            r_c     <= w_c_n;
            if (w_state_n == S_FETCH) begin
                r_rd_x <= w_cx_n - C_OFF + 8'(w_c_n);
                r_rd_y <= w_cy_n - C_OFF + 8'(w_r_n);
            end
            r_pipe_v[0] <= (r_state == S_FETCH);
            r_pipe_x[0] <= r_cx + C_OFF;
            r_pipe_y[0] <= r_cy + C_OFF;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
                r_pipe_x[i] <= r_pipe_x[i-1];
                r_pipe_y[i] <= r_pipe_y[i-1];
            end
            r_dv <= r_pipe_v[MEM_LATENCY-1];
            if (r_pipe_v[MEM_LATENCY-1]) begin
                r_dout <= io_bus.mem_data_in;
                r_xo   <= r_pipe_x[MEM_LATENCY-1];
                r_yo   <= r_pipe_y[MEM_LATENCY-1];
            end
        end
    end

    assign io_bus.busy            = (r_state == S_FETCH) || (r_state == S_GAP) || (r_state == S_DRAIN);
    assign io_bus.done            = (r_state == S_DONE);
    assign io_bus.mem_read_enable = (r_state == S_FETCH);
    assign io_bus.mem_read_x      = r_rd_x;
    assign io_bus.mem_read_y      = r_rd_y;
    assign io_bus.data_valid      = r_dv;
    assign io_bus.data_out        = r_dout;
    assign io_bus.x_address_out   = r_xo;
    assign io_bus.y_address_out   = r_yo;
endmodule

// File: tb/tb_median_window_reader.sv
// tb_median_window_reader: drives a 4x4/latency-1 and a 5x4/latency-3 reader and checks
// every cycle against a window-arithmetic reference model.
module tb_median_window_reader;
    typedef struct packed {
        logic       busy;
        logic       done;
        logic       en;
        logic [7:0] rx;
        logic [7:0] ry;
        logic       dv;
        logic       dout;
        logic [7:0] xo;
        logic [7:0] yo;
    } obs_t;

    typedef struct {
        int inst;
        int mode;
        bit noisy;
        bit chain;
        int exp_first;
        int exp_done;
    } row_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic img [2][8][8];
    logic m0;
    logic m1 [3];
    int   last_rx [2];
    int   last_ry [2];
    int   last_xo [2];
    int   last_yo [2];
    logic [15:0] rd_log [$];
    logic        dv_log [$];
    row_t tbl [6];
    logic [15:0] exp_rd [9];

    median_window_reader_if b0();
    median_window_reader_if b1();

    median_window_reader #(.WINDOW_SIZE(3), .IMG_WIDTH(4), .IMG_HEIGHT(4), .MEM_LATENCY(1))
        u0 (.i_clk(clk), .i_reset_n(reset_n), .io_bus(b0));
    median_window_reader #(.WINDOW_SIZE(3), .IMG_WIDTH(5), .IMG_HEIGHT(4), .MEM_LATENCY(3))
        u1 (.i_clk(clk), .i_reset_n(reset_n), .io_bus(b1));

    always #5 clk = ~clk;

    // Synchronous image memories with the latency each instance expects.
    always @(posedge clk) m0 <= img[0][b0.mem_read_y[2:0]][b0.mem_read_x[2:0]];
    always @(posedge clk) begin
        m1[0] <= img[1][b1.mem_read_y[2:0]][b1.mem_read_x[2:0]];
        m1[1] <= m1[0];
        m1[2] <= m1[1];
    end
    assign b0.mem_data_in = m0;
    assign b1.mem_data_in = m1[2];

    function automatic obs_t sample(int inst);
        obs_t o;
        if (inst == 0)
            o = '{b0.busy, b0.done, b0.mem_read_enable, b0.mem_read_x, b0.mem_read_y,
                  b0.data_valid, b0.data_out, b0.x_address_out, b0.y_address_out};
        else
            o = '{b1.busy, b1.done, b1.mem_read_enable, b1.mem_read_x, b1.mem_read_y,
                  b1.data_valid, b1.data_out, b1.x_address_out, b1.y_address_out};
        return o;
    endfunction

    // Cycle j after the accepting edge carries a read when it falls in one of the
    // nine read slots of a ten-cycle window period.
    function automatic bit is_read(int j, int n);
        return (j >= 1) && (j <= 10 * n - 1) && ((j - 1) % 10 < 9);
    endfunction

    task automatic win_pos(input int j, input int wi, output int cx, output int cy,
                           output int px, output int py);
        int w = (j - 1) / 10;
        int i = (j - 1) % 10;
        cx = 1 + w % (wi - 2);
        cy = 1 + w / (wi - 2);
        px = cx - 1 + i % 3;
        py = cy - 1 + i / 3;
    endtask

    task automatic chk(input string name, input int k, input obs_t g, input obs_t e);
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", name, k, g, e);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic set_start(input int inst, input bit v);
        if (inst == 0) b0.start = v;
        else b1.start = v;
    endtask

    task automatic fill(input int inst, input int mode);
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                img[inst][y][x] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((x + y) & 1)
                                                                   : 1'($urandom_range(0, 1));
    endtask

    task automatic check_zero(input string name);
        chk(name, -1, sample(0), '0);
        chk(name, -1, sample(1), '0);
    endtask

    task automatic reset_seq();
        #2 reset_n = 1'b0;
        #1 check_zero("rst_async");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            b0.start = c[0];
            b1.start = c[0];
            check_zero("rst_hold");
        end
        b0.start = 1'b0;
        b1.start = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            last_rx[i] = 0;
            last_ry[i] = 0;
            last_xo[i] = 0;
            last_yo[i] = 0;
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_zero("rst_idle");
        end
    endtask

    task automatic scan(input int inst, input int mode, input bit noisy, input bit chain,
                        input bit pending, input int abort_k, output int first_dv,
                        output int done_at);
        int wi  = (inst == 1) ? 5 : 4;
        int lat = (inst == 1) ? 3 : 1;
        int n   = (wi - 2) * 2;
        int t   = 10 * n + lat + 1;
        int cx, cy, px, py;
        obs_t e, g;
        fill(inst, mode);
        rd_log.delete();
        dv_log.delete();
        first_dv = -1;
        done_at = -1;
        if (!pending) begin
            set_start(inst, 1'b1);
            @(negedge clk);
        end
        for (int k = 1; k <= t + 1; k++) begin
            set_start(inst, (noisy && k <= t && $urandom_range(0, 3) == 0) || (chain && k == t + 1));
            e = '0;
            e.busy = (k < t);
            e.done = (k == t);
            if (is_read(k, n)) begin
                e.en = 1'b1;
                win_pos(k, wi, cx, cy, px, py);
                last_rx[inst] = px;
                last_ry[inst] = py;
            end
            e.rx = 8'(last_rx[inst]);
            e.ry = 8'(last_ry[inst]);
            if (is_read(k - lat - 1, n)) begin
                win_pos(k - lat - 1, wi, cx, cy, px, py);
                e.dv = 1'b1;
                e.dout = img[inst][py][px];
                last_xo[inst] = cx + 1;
                last_yo[inst] = cy + 1;
            end
            e.xo = 8'(last_xo[inst]);
            e.yo = 8'(last_yo[inst]);
            g = sample(inst);
            if (!e.dv) g.dout = 1'b0;
            chk($sformatf("scan%0d", inst), k, g, e);
            if (g.dv && first_dv < 0) first_dv = k;
            if (g.done && done_at < 0) done_at = k;
            if (g.en && rd_log.size() < 9) rd_log.push_back({g.rx, g.ry});
            if (g.dv && dv_log.size() < 9) dv_log.push_back(g.dout);
            if (k == abort_k) return;
            @(negedge clk);
        end
    endtask

    initial begin
        int fdv, dn;
        bit pend;
        tbl[0] = '{0, 0, 1'b0, 1'b0, 3, 42};
        tbl[1] = '{0, 1, 1'b0, 1'b0, 3, 42};
        tbl[2] = '{0, 2, 1'b1, 1'b1, 3, 42};
        tbl[3] = '{0, 2, 1'b0, 1'b0, 3, 42};
        tbl[4] = '{1, 2, 1'b1, 1'b0, 5, 64};
        tbl[5] = '{1, 1, 1'b0, 1'b0, 5, 64};
        exp_rd = '{16'h0000, 16'h0100, 16'h0200, 16'h0001, 16'h0101,
                   16'h0201, 16'h0002, 16'h0102, 16'h0202};
        b0.start = 1'b0;
        b1.start = 1'b0;
        reset_seq();
        pend = 1'b0;
        for (int r = 0; r < 6; r++) begin
            scan(tbl[r].inst, tbl[r].mode, tbl[r].noisy, tbl[r].chain, pend, -1, fdv, dn);
            chk_int($sformatf("first_dv row%0d", r), fdv, tbl[r].exp_first);
            chk_int($sformatf("done_at row%0d", r), dn, tbl[r].exp_done);
            pend = tbl[r].chain;
            if (tbl[r].inst == 0 && tbl[r].mode == 1) begin
                for (int i = 0; i < 9; i++) begin
                    chk_int($sformatf("cb_addr%0d", i), i < rd_log.size() ? int'(rd_log[i]) : -1,
                            int'(exp_rd[i]));
                    chk_int($sformatf("cb_data%0d", i), i < dv_log.size() ? int'(dv_log[i]) : -1,
                            i % 2);
                end
            end
        end
        // Abort inside the second burst, then a fresh scan must start from window 0.
        scan(0, 2, 1'b0, 1'b0, 1'b0, 16, fdv, dn);
        reset_seq();
        scan(0, 2, 1'b0, 1'b0, 1'b0, -1, fdv, dn);
        chk_int("restart_first", fdv, 3);
        chk_int("restart_done", dn, 42);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
